mem_test_master: RTL

MEM_TEST_MASTER -- requirements
Module: mem_test_master

---
 rtl/mem_test_master_if.sv | 24 ++
 rtl/mem_test_master.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/mem_test_master_if.sv
// rtl/mem_test_master_if.sv - Avalon-MM word bus between the memory tester and the target memory
interface mem_test_master_if #(
    parameter int ADDR_W = 15
);
    logic [ADDR_W-1:0] address;
    logic [3:0]        byteenable;
    logic              chipselect;
    logic              write;
    logic [31:0]       writedata;
    logic              read;
    logic [31:0]       readdata;
    logic              waitrequest;
    logic              readdatavalid;

    modport master (
        output address, byteenable, chipselect, write, writedata, read,
        input  readdata, waitrequest, readdatavalid
    );

    modport slave (
        input  address, byteenable, chipselect, write, writedata, read,
        output readdata, waitrequest, readdatavalid
    );
endinterface

// File: rtl/mem_test_master.sv
// rtl/mem_test_master.sv - writes an incrementing pattern over a word range, reads it back and counts mismatches
module mem_test_master #(
    parameter int DEPTH  = 20480,
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W-1:0] count,
    input  logic [31:0]       seed,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [15:0]       err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    mem_test_master_if.master avm
);
    localparam int                CNT_W     = ADDR_W + 1;
    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [2:0] {IDLE, WRITE, RD_REQ, RD_WAIT, FINISH} state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  k, last_k, count_cl;
    logic [ADDR_W-1:0] base_q, cur_addr;
    logic [31:0]       seed_q, cur_pat;
    logic              abort_pend, have_err;
    logic              launch, step, rewind, compare, set_abort, ab, is_last;

    assign count_cl = ({1'b0, count} > DEPTH_C) ? DEPTH_C : {1'b0, count};
    assign ab       = abort_pend | abort;
    assign is_last  = (k == last_k);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        launch         = 1'b0;
        step           = 1'b0;
        rewind         = 1'b0;
        compare        = 1'b0;
        set_abort      = 1'b0;
        avm.chipselect = 1'b0;
        avm.write      = 1'b0;
        avm.read       = 1'b0;
        avm.byteenable = 4'h0;
        avm.writedata  = 32'h0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    launch    = 1'b1;
                    state_nxt = (count == '0) ? FINISH : WRITE;
                end
            end
            WRITE: begin
                avm.chipselect = 1'b1;
                avm.write      = 1'b1;
                avm.byteenable = 4'hF;
                avm.writedata  = cur_pat;
                if (!avm.waitrequest) begin
                    if (ab) begin
                        state_nxt = FINISH;
                        set_abort = 1'b1;
                    end else if (is_last) begin
                        state_nxt = RD_REQ;
                        rewind    = 1'b1;
                    end else begin
                        step = 1'b1;
                    end
                end
            end
            RD_REQ: begin
                avm.chipselect = 1'b1;
                avm.read       = 1'b1;
                avm.byteenable = 4'hF;
                if (!avm.waitrequest) state_nxt = RD_WAIT;
            end
            RD_WAIT: begin
                if (avm.readdatavalid) begin
                    compare = 1'b1;
                    if (ab) begin
                        state_nxt = FINISH;
                        set_abort = 1'b1;
                    end else if (is_last) begin
                        state_nxt = FINISH;
                    end else begin
                        state_nxt = RD_REQ;
                        step      = 1'b1;
                    end
                end
            end
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign avm.address = cur_addr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            k              <= '0;
            last_k         <= '0;
            base_q         <= '0;
            seed_q         <= '0;
            cur_addr       <= '0;
            cur_pat        <= '0;
            abort_pend     <= 1'b0;
            have_err       <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            aborted        <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
        end else begin
            done <= (state == FINISH);
            if (state == FINISH) busy <= 1'b0;

            if (launch) begin
                base_q         <= base;
                seed_q         <= seed;
                cur_addr       <= base;
                cur_pat        <= seed;
                k              <= '0;
                last_k         <= count_cl - 1'b1;
                err_count      <= '0;
                first_err_addr <= '0;
                have_err       <= 1'b0;
                aborted        <= 1'b0;
                abort_pend     <= abort;
                busy           <= 1'b1;
            end else if (busy && abort) begin
                abort_pend <= 1'b1;
            end

            if (step) begin
                k        <= k + 1'b1;
                cur_addr <= (cur_addr == LAST_ADDR) ? '0 : cur_addr + 1'b1;
                cur_pat  <= cur_pat + 32'd1;
            end else if (rewind) begin
                k        <= '0;
                cur_addr <= base_q;
                cur_pat  <= seed_q;
            end

            // first_err_addr must reflect the word being compared, before step moves cur_addr on
            if (compare && (avm.readdata != cur_pat)) begin
                if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
                if (!have_err) begin
                    first_err_addr <= cur_addr;
                    have_err       <= 1'b1;
                end
            end

            if (set_abort) aborted <= 1'b1;
        end
    end
endmodule
